// File: rtl/mux64_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux64_rr_arbiter_pkg
//  Purpose  : Shared definitions for the 64-way round-robin arbiter slice.
//             Holds the requester count, the index width and the two-state
//             output register encoding.
//  Revision : 1.0  initial release
// ============================================================================
package mux64_rr_arbiter_pkg;

  localparam int ARB_N     = 64;
  localparam int ARB_IDX_W = 6;

  // Output register state: EMPTY means out_valid=0, FULL means out_valid=1.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage : mux64_rr_arbiter_pkg
`default_nettype wire

// File: rtl/mux64_rr_arbiter_mux64.sv
`default_nettype none
// ============================================================================
//  Module   : mux64
//  Purpose  : 64:1 payload multiplexer.
//  Ports    : ins  - 64 packed payload words of WIDTH bits
//             sel  - 6-bit select index
//             out  - selected payload word
//  Revision : 1.0  initial release
// ============================================================================
module mux64
  import mux64_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [ARB_N-1:0][WIDTH-1:0] ins,
  input  logic [ARB_IDX_W-1:0]        sel,
  output logic [WIDTH-1:0]            out
);

  assign out = ins[sel];

endmodule : mux64
`default_nettype wire

// File: rtl/mux64_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux64_rr_arbiter
//  Purpose  : 64-requester round-robin arbiter with a one-entry registered
//             output. The grant scans from the round-robin pointer upward
//             with wrap; the granted payload is captured into the output
//             register whenever that register is empty or being drained.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             req_valid  - per-requester request
//             req_data   - per-requester payload
//             req_ready  - per-requester accept (one-hot or zero)
//             out_valid  - output register holds a granted payload
//             out_ready  - downstream consumes the output this cycle
//             out_data   - granted payload (registered)
//             out_idx    - index of the granted requester (registered)
//  Revision : 1.0  initial release
// ============================================================================
module mux64_rr_arbiter
  import mux64_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ARB_N-1:0]            req_valid,
  input  logic [ARB_N-1:0][WIDTH-1:0] req_data,
  output logic [ARB_N-1:0]            req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [ARB_IDX_W-1:0]        out_idx
);

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [ARB_IDX_W-1:0] r_ptr;
  logic [ARB_IDX_W-1:0] w_grant;
  logic [ARB_N-1:0]     w_onehot;
  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_any;
  logic                 w_capture;

  // --------------------------------------------------------------------------
  // Rotating priority scan. Iterating offsets from high to low lets the
  // smallest offset from r_ptr win; the 6-bit sum wraps 63 -> 0 naturally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant = r_ptr;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      if (req_valid[r_ptr + ARB_IDX_W'(k)]) begin
        w_grant = r_ptr + ARB_IDX_W'(k);
      end
    end
  end

  assign w_any     = |req_valid;
  assign w_capture = w_any & ((r_state == ST_EMPTY) | out_ready);

  always_comb begin
    w_onehot          = '0;
    w_onehot[w_grant] = 1'b1;
  end

  // Accept is gated by rst so nothing is handshaken while the block is held
  // in reset; it depends only on req_valid and state, never on req_data.
  assign req_ready = (w_capture & ~rst) ? w_onehot : '0;

  mux64 #(
    .WIDTH (WIDTH)
  ) u_mux64 (
    .ins (req_data),
    .sel (w_grant),
    .out (w_sel_data)
  );

  // --------------------------------------------------------------------------
  // Output FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_capture) begin
      w_state_next = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_next = ST_EMPTY;
    end
  end

  // Output FSM: output logic
  always_comb begin
    out_valid = (r_state == ST_FULL);
  end

  // --------------------------------------------------------------------------
  // Payload / index registers and round-robin pointer. These only move on a
  // capture, so a drain with no new request leaves out_data/out_idx intact.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_idx  <= '0;
      r_ptr    <= '0;
    end else if (w_capture) begin
      out_data <= w_sel_data;
      out_idx  <= w_grant;
      r_ptr    <= w_grant + ARB_IDX_W'(1);
    end
  end

endmodule : mux64_rr_arbiter
`default_nettype wire

// File: tb/tb_mux64_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux64_rr_arbiter
//  Purpose  : Directed self-checking bench for mux64_rr_arbiter (WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux64_rr_arbiter;

  localparam int W = 8;

  logic              clk;
  logic              rst;
  logic [63:0]       req_valid;
  logic [63:0][W-1:0] req_data;
  logic [63:0]       req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [5:0]        out_idx;

  int vectors;
  int miscompares;

  mux64_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct payload per requester.
  function automatic logic [W-1:0] pay(input int i);
    return W'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [63:0] bit1(input int i);
    logic [63:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One cycle with no request and out_ready high so the output drains.
  task automatic drain();
    @(negedge clk);
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  // Apply a request pattern, check the combinational accept, then check the
  // registered result after the edge.
  task automatic grant_step(input string name, input logic [63:0] rv,
                            input int exp_g);
    @(negedge clk);
    req_valid = rv;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== bit1(exp_g)) begin
      miscompares++;
      $display("FAIL %s req_ready: got %h want %h", name, req_ready, bit1(exp_g));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 6'(exp_g) || out_data !== pay(exp_g)) begin
      miscompares++;
      $display("FAIL %s out: got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h",
               name, out_valid, out_idx, out_data, exp_g, pay(exp_g));
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h idx=%0d want 0/0/0",
               out_valid, out_data, out_idx);
    end
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %h want 0", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single();
    grant_step("single_bit5", bit1(5), 5);
    drain();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_idx !== 6'd5 || out_data !== pay(5)) begin
      miscompares++;
      $display("FAIL drain_hold: got v=%b idx=%0d d=%h want v=0 idx=5 d=%h",
               out_valid, out_idx, out_data, pay(5));
    end
  endtask

  task automatic test_wrap();
    grant_step("wrap_first", bit1(3) | bit1(40), 40);
    grant_step("wrap_second", bit1(3), 3);
    // ptr should now be 4, so 4 beats 3.
    grant_step("wrap_ptr4", bit1(3) | bit1(4), 4);
    drain();
  endtask

  task automatic test_all();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      grant_step("all_rr", '1, c % 64);
    end
    drain();
  endtask

  task automatic test_backpressure();
    grant_step("bp_fill", bit1(20), 20);
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = bit1(9);
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (req_ready !== '0) begin
        miscompares++;
        $display("FAIL bp_req_ready: got %h want 0", req_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 6'd20 || out_data !== pay(20)) begin
        miscompares++;
        $display("FAIL bp_hold: got v=%b idx=%0d d=%h want v=1 idx=20 d=%h",
                 out_valid, out_idx, out_data, pay(20));
      end
      @(negedge clk);
    end
    // ptr is 21; scan wraps round to 9.
    grant_step("bp_release", bit1(9), 9);
    drain();
  endtask

  task automatic test_bit63();
    grant_step("b63_first", bit1(63), 63);
    grant_step("b63_again", bit1(63), 63);
    // ptr wrapped to 0, so 0 beats 63.
    grant_step("b63_ptr0", bit1(0) | bit1(63), 0);
    drain();
  endtask

  task automatic test_reset_mid();
    grant_step("rm_fill", bit1(7), 7);
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = bit1(7);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0) begin
      miscompares++;
      $display("FAIL rm_async: got v=%b d=%h idx=%0d want 0/0/0",
               out_valid, out_data, out_idx);
    end
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL rm_req_ready: got %h want 0", req_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_no_replay: got out_valid=%b want 0", out_valid);
    end
    grant_step("rm_first", bit1(2) | bit1(0), 0);
    grant_step("rm_second", bit1(2), 2);
    drain();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) req_data[i] = pay(i);
    test_reset();
    test_single();
    test_wrap();
    test_all();
    test_backpressure();
    test_bit63();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux64_rr_arbiter
`default_nettype wire
